// File: rtl/led_bank_scheduler.sv
// Round-robin LED bank scheduler: grants one of four pattern sources per dwell slot.
// Optional macro LED_SCHED_PRIO_EN makes source 0 preemptive.
module led_bank_scheduler #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned DWELL_TICKS = 8
) (
  input  logic        SYS_CLK,
  input  logic        RESET,
  input  logic [3:0]  REQ,
  input  logic [31:0] PAT,
  input  logic        HOLD,
  output logic [3:0]  GRANT,
  output logic [3:0]  ADV_TICK,
  output logic [7:0]  LED_OUT,
  output logic [1:0]  ACTIVE_IDX,
  output logic        BUSY
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CNT_W    = $clog2(TICK_DIV);
  localparam int unsigned DWELL_W  = 8;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               tick_c;
  logic               tick_n;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_n;
  logic [1:0]         idx_n;
  logic [3:0]         grant_n;
  logic               preempt_c;
  logic [2:0]         first_c;
  logic [2:0]         rr_c;

  // First requester at or after start (mod 4); returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] cand;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (req[cand]) pick = {1'b1, cand};
    end
    return pick;
  endfunction

  assign first_c = rr_pick(REQ, 2'd0);
  assign rr_c    = rr_pick(REQ, ACTIVE_IDX + 2'd1);

`ifdef LED_SCHED_PRIO_EN
  assign preempt_c = REQ[0] && (ACTIVE_IDX != 2'd0);
`else
  assign preempt_c = 1'b0;
`endif

  // Free-running prescaler; tick_n anticipates the tick so ADV_TICK can be registered.
  always_comb begin
    tick_c = (cnt == CNT_LAST);
    cnt_n  = tick_c ? '0 : cnt + CNT_W'(1);
    tick_n = (cnt_n == CNT_LAST);
  end

  // Next-state, grant selection and dwell accounting.
  always_comb begin
    state_n = state;
    idx_n   = ACTIVE_IDX;
    dwell_n = dwell;
    case (state)
      S_IDLE: begin
        if (first_c[2]) begin
          state_n = S_GRANT;
          idx_n   = first_c[1:0];
          dwell_n = '0;
        end
      end
      S_GRANT: begin
        if (preempt_c) begin
          idx_n   = 2'd0;
          dwell_n = '0;
        end else if (!REQ[ACTIVE_IDX]) begin
          dwell_n = '0;
          if (rr_c[2]) begin
            idx_n = rr_c[1:0];
          end else begin
            state_n = S_IDLE;
            idx_n   = 2'd0;
          end
        end else if (tick_c && !HOLD) begin
          // Active source still requests, so rr_c always finds someone (possibly itself).
          if (dwell == DWELL_LAST) begin
            dwell_n = '0;
            idx_n   = rr_c[1:0];
          end else begin
            dwell_n = dwell + DWELL_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = 2'd0;
        dwell_n = '0;
      end
    endcase
    grant_n = (state_n == S_GRANT) ? (4'b0001 << idx_n) : 4'b0000;
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dwell      <= '0;
      ACTIVE_IDX <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dwell      <= dwell_n;
      ACTIVE_IDX <= idx_n;
    end
  end

  // LED_OUT follows the grant held during the previous cycle.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      GRANT    <= 4'b0000;
      ADV_TICK <= 4'b0000;
      BUSY     <= 1'b0;
      LED_OUT  <= 8'h00;
    end else begin
      GRANT    <= grant_n;
      ADV_TICK <= grant_n & {4{tick_n}};
      BUSY     <= (state_n == S_GRANT);
      LED_OUT  <= BUSY ? PAT[{ACTIVE_IDX, 3'b000} +: 8] : 8'h00;
    end
  end

endmodule

// File: doc/led_bank_scheduler.md
LED_BANK_SCHEDULER -- requirements
Module: led_bank_scheduler

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, SHALL be the SYS_CLK frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, SHALL be the scheduler tick rate; TICK_DIV = CLK_FREQ/TICK_HZ, and TICK_DIV >= 2.
REQ-003 Parameter DWELL_TICKS, default 8, range 1..255, SHALL be the slot length in ticks.
REQ-004 Port list SHALL be exactly:
- SYS_CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  4  request per pattern source i=0..3.
- PAT  in  32  source i pattern on PAT[8i+7:8i].
- HOLD  in  1  freezes the slot dwell count.
- GRANT  out  4  one-hot grant, 0 when idle.
- ADV_TICK  out  4  one-cycle tick strobe to the granted source only.
- LED_OUT  out  8  scheduled LED bank drive.
- ACTIVE_IDX  out  2  index of granted source, 0 when idle.
- BUSY  out  1  high while any grant is active.

Function
REQ-005 The prescaler SHALL count 0..TICK_DIV-1 and wrap; tick = (count == TICK_DIV-1), one cycle wide, free-running regardless of state.
REQ-006 The FSM SHALL have states IDLE and GRANT.
REQ-007 IDLE: if any REQ is high at cycle k, the FSM SHALL enter GRANT at k+1 with the lowest-index requester.
REQ-008 On entering GRANT, the dwell counter SHALL clear to 0.
REQ-009 In GRANT, each tick with HOLD low SHALL increment the dwell counter; ADV_TICK[active] = tick regardless of HOLD.
REQ-010 Slot expiry occurs on the tick at which the dwell counter would reach DWELL_TICKS.
REQ-011 On slot expiry, the next grant SHALL be chosen round-robin from active+1 (mod 4). If no other source requests and active still requests, the same source SHALL be re-granted with the dwell counter cleared.
REQ-012 If REQ[active] falls in GRANT, at the next cycle the FSM SHALL grant the next requester round-robin, or go to IDLE if none.
REQ-013 GRANT, ACTIVE_IDX and BUSY SHALL be registered and mutually consistent every cycle.
REQ-014 LED_OUT SHALL be registered: the value at k+1 = PAT byte of the source granted at k, or 8'h00 if idle at k.
REQ-015 At most one GRANT bit SHALL be high at any time.
REQ-016 On any grant change, ADV_TICK SHALL never strobe a non-granted source.
REQ-017 Dwell counter width SHALL be 8 bits, and it SHALL never exceed DWELL_TICKS-1.

Reset
REQ-018 While RESET is high: FSM=IDLE; prescaler, dwell and all outputs SHALL be 0.
REQ-019 Reset asserted mid-slot SHALL abort the slot immediately (asynchronously).
REQ-020 After RESET deasserts, scheduling SHALL restart per REQ-007, and the prescaler SHALL restart from 0.

Configuration
REQ-021 Macro LED_SCHED_PRIO_EN, when defined, SHALL make source 0 preemptive: REQ[0] high while another source is granted at cycle k SHALL grant source 0 at k+1 with the dwell counter cleared. Source 0's own slot SHALL still rotate per REQ-011.
REQ-022 Without LED_SCHED_PRIO_EN, all sources SHALL be equal round-robin, and no preemption SHALL occur.

Verification
Bench parameters: CLK_FREQ=8, TICK_HZ=1 (tick every 8 cycles), DWELL_TICKS=2.
REQ-023 Idle/grant: REQ=4'b0000 for 20 cycles -> GRANT=0, LED_OUT=00, BUSY=0. Then REQ=4'b0100, PAT[23:16]=A5 at cycle k -> GRANT=0100 at k+1, LED_OUT=A5 at k+2.
REQ-024 Rotation: REQ=4'b1011 held -> grant order 0,1,3,0, each slot lasting 2 ticks (16 cycles). ADV_TICK pulses only on the granted bit.
REQ-025 Drop and sole requester: during source 1's slot, REQ[1] falls at k -> GRANT=1000 at k+1. With only REQ[3] high, source 3 is re-granted after expiry with no idle cycle.
REQ-026 HOLD: HOLD=1 for 5 ticks mid-slot -> no rotation, ADV_TICK still strobes. After HOLD=0, the remaining ticks complete the slot.
REQ-027 Reset mid-slot: RESET pulsed for 1 cycle while GRANT=0010 -> all outputs 0 in that cycle, IDLE afterward, re-grant per REQ-007.
REQ-028 Preemption (LED_SCHED_PRIO_EN defined): source 2 granted, REQ[0] rises at k -> GRANT=0001 at k+1. With the macro undefined, same stimulus -> source 2 keeps its full slot.
